mem_io_responder: RTL and testbench

Memory-side responder for the CPU's byte-wide memory bus (address/data-out/write strobe in, data-in out, `io_buffer_full` out). It holds the 128 KB program/data RAM and decodes the I/O window at `mem_a[17:16]==2'b11`. In that window it provides a UART transmit FIFO, a UART receive read port, a free-running cycle counter and the program-stop flag. It sits between the CPU's memory bus and the UART blocks, and implements the bus contract the CPU depends on: read data one cycle after the address, writes complete in one cycle.

---
 rtl/mem_io_responder.sv | 118 +++++++++++
 tb/tb_mem_io_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - CPU memory-bus responder: 128 KB RAM, UART TX FIFO/RX port, cycle counter, stop flag
module mem_io_responder #(
   parameter int RAM_ADDR_WIDTH = 17,
   parameter int TX_DEPTH       = 16,
   parameter int TX_MARGIN      = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_pop,
   output logic        program_done,
   output logic [31:0] cycle_count
);
   localparam int PW = $clog2(TX_DEPTH);

   logic [7:0]                ram [0:(1 << RAM_ADDR_WIDTH) - 1];
   logic [7:0]                ram_q;
   logic                      ram_sel_q;
   logic [7:0]                io_q;
   logic [31:0]               cnt_snap;
   logic [RAM_ADDR_WIDTH-1:0] ram_addr;

   logic [7:0]    tx_mem [0:TX_DEPTH-1];
   logic [PW-1:0] head, tail;
   logic [PW:0]   count, next_count, free_next;

   logic       is_ram, is_io;
   logic [2:0] reg_sel;
   logic       wr_tx, wr_stop, push_req, push_ok, pop;
   logic [7:0] push_data;
   logic       unused_bits;

   assign ram_addr    = mem_a[RAM_ADDR_WIDTH-1:0];
   assign is_ram      = ~mem_a[17];
   assign is_io       = (mem_a[17:16] == 2'b11);
   assign reg_sel     = mem_a[2:0];
   assign unused_bits = ^mem_a[31:18];

   assign rx_pop = ~rst_in & ~mem_wr & is_io & (reg_sel == 3'd0) & rx_valid;

   // A zero byte written to the data port is swallowed; the stop write queues the terminator.
   assign wr_tx     = mem_wr & is_io & (reg_sel == 3'd0) & (mem_dout != 8'h00);
   assign wr_stop   = mem_wr & is_io & (reg_sel == 3'd4);
   assign push_req  = wr_tx | wr_stop;
   assign push_data = wr_stop ? 8'h00 : mem_dout;

   assign tx_valid   = (count != '0);
   assign tx_data    = tx_valid ? tx_mem[head] : 8'h00;
   assign pop        = tx_valid & tx_ready;
   assign push_ok    = push_req & ((count != (PW+1)'(TX_DEPTH)) | pop);
   assign next_count = count + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop};
   assign free_next  = (PW+1)'(TX_DEPTH) - next_count;

   assign mem_din = ram_sel_q ? ram_q : io_q;

   always_ff @(posedge clk_in) begin
      if (!rst_in && mem_wr && is_ram)
         ram[ram_addr] <= mem_dout;
      if (!mem_wr)
         ram_q <= ram[ram_addr];
   end

   always_ff @(posedge clk_in) begin
      if (push_ok)
         tx_mem[tail] <= push_data;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         ram_sel_q      <= 1'b0;
         io_q           <= 8'h00;
         cnt_snap       <= 32'd0;
         cycle_count    <= 32'd0;
         program_done   <= 1'b0;
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         io_buffer_full <= 1'b0;
      end else begin
         cycle_count <= cycle_count + 32'd1;
         // mem_din holds the last read result across write cycles.
         if (!mem_wr) begin
            ram_sel_q <= is_ram;
            io_q      <= 8'h00;
            if (is_io) begin
               case (reg_sel)
                  3'd0: if (rx_valid) io_q <= rx_data;
                  3'd4: begin
                     io_q     <= cycle_count[7:0];
                     cnt_snap <= cycle_count;
                  end
                  3'd5: io_q <= cnt_snap[15:8];
                  3'd6: io_q <= cnt_snap[23:16];
                  3'd7: io_q <= cnt_snap[31:24];
                  default: io_q <= 8'h00;
               endcase
            end
         end
         if (wr_stop)
            program_done <= 1'b1;
         if (push_ok)
            tail <= tail + PW'(1);
         if (pop)
            head <= head + PW'(1);
         count          <= next_count;
         io_buffer_full <= (free_next <= (PW+1)'(TX_MARGIN));
      end
   end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - directed bench with a queue-based reference model for mem_io_responder
module tb_mem_io_responder;
   localparam int TX_DEPTH  = 16;
   localparam int TX_MARGIN = 2;

   logic        clk_in;
   logic        rst_in;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_pop;
   logic        program_done;
   logic [31:0] cycle_count;

   mem_io_responder #(.RAM_ADDR_WIDTH(17), .TX_DEPTH(TX_DEPTH), .TX_MARGIN(TX_MARGIN)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
      .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
      .program_done(program_done), .cycle_count(cycle_count)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: bus semantics in plain arithmetic, a byte queue for the TX FIFO.
   bit          started = 0;
   logic [7:0]  mram [int];
   logic [7:0]  mq [$];
   logic [7:0]  m_din;
   logic        m_done;
   logic        m_full;
   logic [31:0] m_cnt;
   logic [31:0] m_snap;
   bit          m_pop, m_push;
   logic [7:0]  m_pv;

   always @(posedge clk_in) begin
      if (rst_in) begin
         started = 1;
         mq.delete();
         m_din = 0; m_done = 0; m_full = 0; m_cnt = 0; m_snap = 0;
      end else begin
         m_pop  = (mq.size() != 0) && tx_ready;
         m_push = 0;
         m_pv   = 0;
         if (mem_wr) begin
            if (mem_a[17] == 1'b0)
               mram[int'(mem_a[16:0])] = mem_dout;
            else if (mem_a[17:16] == 2'b11) begin
               if (mem_a[2:0] == 3'd0 && mem_dout != 0) begin m_push = 1; m_pv = mem_dout; end
               if (mem_a[2:0] == 3'd4) begin m_push = 1; m_pv = 8'h00; m_done = 1; end
            end
         end else begin
            if (mem_a[17] == 1'b0)
               m_din = mram[int'(mem_a[16:0])];
            else if (mem_a[17:16] == 2'b10)
               m_din = 0;
            else begin
               case (mem_a[2:0])
                  3'd0: m_din = rx_valid ? rx_data : 8'h00;
                  3'd4: begin m_din = m_cnt[7:0]; m_snap = m_cnt; end
                  3'd5: m_din = m_snap[15:8];
                  3'd6: m_din = m_snap[23:16];
                  3'd7: m_din = m_snap[31:24];
                  default: m_din = 0;
               endcase
            end
         end
         if (m_pop) void'(mq.pop_front());
         if (m_push && mq.size() < TX_DEPTH) mq.push_back(m_pv);
         m_full = (TX_DEPTH - mq.size()) <= TX_MARGIN;
         m_cnt  = m_cnt + 1;
      end
   end

   always @(negedge clk_in) begin
      if (started) begin
         chk("mem_din", {24'd0, mem_din}, {24'd0, m_din});
         chk("io_buffer_full", {31'd0, io_buffer_full}, {31'd0, m_full});
         chk("tx_valid", {31'd0, tx_valid}, (mq.size() != 0) ? 32'd1 : 32'd0);
         chk("tx_data", {24'd0, tx_data}, (mq.size() != 0) ? {24'd0, mq[0]} : 32'd0);
         chk("rx_pop", {31'd0, rx_pop},
             (!rst_in && !mem_wr && mem_a[17:16] == 2'b11 && mem_a[2:0] == 3'd0 && rx_valid) ? 32'd1 : 32'd0);
         chk("program_done", {31'd0, program_done}, {31'd0, m_done});
         chk("cycle_count", cycle_count, m_cnt);
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle();
      mem_a = 32'h0002_0000; mem_wr = 1'b0; mem_dout = 8'h00;
   endtask

   task automatic wr(input logic [31:0] a, input logic [7:0] d);
      mem_a = a; mem_wr = 1'b1; mem_dout = d;
      tick();
      idle();
   endtask

   task automatic rd(input logic [31:0] a);
      mem_a = a; mem_wr = 1'b0;
      tick();
      idle();
   endtask

   logic [7:0] b [4];
   logic [7:0] got [16];

   initial begin
      rst_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      idle();
      repeat (3) tick();
      chk("rst mem_din", {24'd0, mem_din}, 32'd0);
      chk("rst tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst program_done", {31'd0, program_done}, 32'd0);
      chk("rst cycle_count", cycle_count, 32'd0);
      chk("rst io_buffer_full", {31'd0, io_buffer_full}, 32'd0);

      // counter snapshot 300 cycles after reset release
      rst_in = 1'b0;
      repeat (300) tick();
      for (int i = 0; i < 4; i++) begin
         mem_a = 32'h0003_0004 + 32'(i); mem_wr = 1'b0;
         tick();
         b[i] = mem_din;
      end
      idle();
      chk("cnt byte0", {24'd0, b[0]}, 32'h2C);
      chk("cnt snapshot", {b[3], b[2], b[1], b[0]}, 32'h0000_012C);

      // RAM and unmapped
      wr(32'h0000_0123, 8'hA5);
      rd(32'h0000_0123);
      chk("ram rd 0x123", {24'd0, mem_din}, 32'hA5);
      wr(32'h0001_FFFF, 8'h3C);
      rd(32'h0001_FFFF);
      chk("ram rd 0x1ffff", {24'd0, mem_din}, 32'h3C);
      wr(32'h0002_0010, 8'h77);
      rd(32'h0002_0010);
      chk("unmapped rd", {24'd0, mem_din}, 32'h00);
      rd(32'h0003_0003);

      // basic TX with zero byte skipped
      wr(32'h0003_0000, 8'h48);
      wr(32'h0003_0000, 8'h00);
      wr(32'h0003_0000, 8'h69);
      chk("tx head 0x48", {24'd0, tx_data}, 32'h48);
      tx_ready = 1'b1;
      tick();
      chk("tx head 0x69", {24'd0, tx_data}, 32'h69);
      tick();
      chk("tx drained", {31'd0, tx_valid}, 32'd0);
      tx_ready = 1'b0;

      // fill to near-full and beyond
      for (int i = 0; i < 14; i++) begin
         wr(32'h0003_0000, 8'(i + 1));
         if (i == 12) chk("flag at 13", {31'd0, io_buffer_full}, 32'd0);
      end
      chk("flag at 14", {31'd0, io_buffer_full}, 32'd1);
      wr(32'h0003_0000, 8'd15);
      wr(32'h0003_0000, 8'd16);
      wr(32'h0003_0000, 8'h99);
      mem_a = 32'h0003_0000; mem_wr = 1'b1; mem_dout = 8'hEE; tx_ready = 1'b1;
      tick();
      idle();
      chk("full push+pop flag", {31'd0, io_buffer_full}, 32'd1);
      for (int i = 0; i < 16; i++) begin
         got[i] = tx_data;
         tick();
         if (i == 1) chk("flag at 14 drain", {31'd0, io_buffer_full}, 32'd1);
         if (i == 2) chk("flag at 13 drain", {31'd0, io_buffer_full}, 32'd0);
      end
      tx_ready = 1'b0;
      chk("drain first", {24'd0, got[0]}, 32'h02);
      chk("drain 15th", {24'd0, got[14]}, 32'h10);
      chk("drain last", {24'd0, got[15]}, 32'hEE);
      chk("drain empty", {31'd0, tx_valid}, 32'd0);

      // RX read port
      rx_valid = 1'b1; rx_data = 8'h37;
      mem_a = 32'h0003_0000; mem_wr = 1'b0;
      #1;
      chk("rx_pop pulse", {31'd0, rx_pop}, 32'd1);
      tick();
      chk("rx data", {24'd0, mem_din}, 32'h37);
      idle();
      #1;
      chk("rx_pop off", {31'd0, rx_pop}, 32'd0);
      rx_valid = 1'b0;
      mem_a = 32'h0003_0000;
      #1;
      chk("rx_pop empty", {31'd0, rx_pop}, 32'd0);
      tick();
      chk("rx empty data", {24'd0, mem_din}, 32'h00);
      idle();

      // stop write
      wr(32'h0003_0004, 8'h5A);
      chk("program_done", {31'd0, program_done}, 32'd1);
      chk("terminator valid", {31'd0, tx_valid}, 32'd1);
      chk("terminator byte", {24'd0, tx_data}, 32'h00);
      wr(32'h0003_0000, 8'h41);

      // reset mid-operation keeps RAM, clears FIFO
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      chk("mid rst tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("mid rst done", {31'd0, program_done}, 32'd0);
      chk("mid rst count", cycle_count, 32'd0);
      rd(32'h0000_0123);
      chk("ram kept", {24'd0, mem_din}, 32'hA5);
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
